// File: rtl/wb_scheduler.sv
// Write-back scheduler: round-robin arbitration of REQ_NUM requesters onto the single
// register-file write port, plus a pending-write scoreboard for RAW hazard detection.
module wb_scheduler #(
  parameter int unsigned REQ_NUM = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REQ_NUM-1:0]      req_valid_i,
  input  logic [REQ_NUM*5-1:0]    req_addr_i,
  input  logic [REQ_NUM*32-1:0]   req_data_i,
  output logic [REQ_NUM-1:0]      req_ready_o,
  input  logic                    flush_i,
  input  logic                    issue_en_i,
  input  logic [4:0]              issue_rd_i,
  input  logic [4:0]              rs1_addr_i,
  input  logic [4:0]              rs2_addr_i,
  output logic                    rs1_busy_o,
  output logic                    rs2_busy_o,
  output logic                    w_en_o,
  output logic [4:0]              w_addr_o,
  output logic [31:0]             w_data_o
);

  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  valid_ext, grant_ext;
  logic [1:0]  grant_idx;
  logic [2:0]  idx;
  logic        xfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic        w_en_q, w_en_d;
  logic [4:0]  w_addr_q, w_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic [31:0] pend_q, pend_d;

  // Walk candidates from the farthest to the nearest so the last hit (closest to ptr) wins.
  always_comb begin
    valid_ext = 4'(req_valid_i);
    grant_ext = '0;
    grant_idx = '0;
    idx       = '0;
    if (!flush_i) begin
      for (int i = int'(REQ_NUM) - 1; i >= 0; i--) begin
        idx = {1'b0, ptr_q} + 3'(i);
        if (idx >= 3'(REQ_NUM)) idx = idx - 3'(REQ_NUM);
        if (valid_ext[idx[1:0]]) begin
          grant_ext = '0;
          grant_ext[idx[1:0]] = 1'b1;
          grant_idx = idx[1:0];
        end
      end
    end
  end

  assign req_ready_o = grant_ext[REQ_NUM-1:0];
  assign xfer        = |grant_ext;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < int'(REQ_NUM); k++) begin
      if (req_ready_o[k]) begin
        sel_addr = req_addr_i[5*k +: 5];
        sel_data = req_data_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (grant_idx == 2'(REQ_NUM - 1)) ? 2'd0 : grant_idx + 2'd1;
  end

  // Idle or x0 write presents addr 0 / data 0 so register-file forwarding yields 0.
  always_comb begin
    w_en_d   = xfer && (sel_addr != 5'd0);
    w_addr_d = w_en_d ? sel_addr : 5'd0;
    w_data_d = w_en_d ? sel_data : 32'd0;
  end

  // Set after clear: a freshly issued producer outranks the commit of the old one.
  always_comb begin
    pend_d = pend_q;
    if (w_en_q) pend_d[w_addr_q] = 1'b0;
    if (issue_en_i && (issue_rd_i != 5'd0)) pend_d[issue_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      pend_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      pend_q   <= pend_d;
    end
  end

  assign w_en_o   = w_en_q;
  assign w_addr_o = w_addr_q;
  assign w_data_o = w_data_q;

  // The in-flight write is forwarded by the register file, so it does not count as busy.
  assign rs1_busy_o = pend_q[rs1_addr_i] & ~(w_en_q && (w_addr_q == rs1_addr_i));
  assign rs2_busy_o = pend_q[rs2_addr_i] & ~(w_en_q && (w_addr_q == rs2_addr_i));

  for (genvar k = 0; k < int'(REQ_NUM); k++) begin : g_hold_chk
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      req_valid_i[k] && !req_ready_o[k] |=>
        req_valid_i[k] && $stable(req_addr_i[5*k +: 5]) && $stable(req_data_i[32*k +: 32]));
  end

  a_issue_free: assert property (@(posedge clk) disable iff (!rst_n)
    issue_en_i && (issue_rd_i != 5'd0) |->
      !pend_q[issue_rd_i] || (w_en_q && (w_addr_q == issue_rd_i)));

endmodule

// File: tb/tb_wb_scheduler.sv
// Directed self-checking bench for wb_scheduler (REQ_NUM = 3).
module tb_wb_scheduler;
  localparam int unsigned N = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N*5-1:0]  req_addr_i = '0;
  logic [N*32-1:0] req_data_i = '0;
  logic [N-1:0]    req_ready_o;
  logic            flush_i = 1'b0;
  logic            issue_en_i = 1'b0;
  logic [4:0]      issue_rd_i = '0;
  logic [4:0]      rs1_addr_i = '0;
  logic [4:0]      rs2_addr_i = '0;
  logic            rs1_busy_o, rs2_busy_o, w_en_o;
  logic [4:0]      w_addr_o;
  logic [31:0]     w_data_o;

  int n_cmp = 0;
  int n_err = 0;

  wb_scheduler #(.REQ_NUM(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .flush_i     (flush_i),
    .issue_en_i  (issue_en_i),
    .issue_rd_i  (issue_rd_i),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .rs1_busy_o  (rs1_busy_o),
    .rs2_busy_o  (rs2_busy_o),
    .w_en_o      (w_en_o),
    .w_addr_o    (w_addr_o),
    .w_data_o    (w_data_o)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid_i[k]         = v;
    req_addr_i[5*k +: 5]   = a;
    req_data_i[32*k +: 32] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid_i = '0; req_addr_i = '0; req_data_i = '0;
    flush_i = 1'b0; issue_en_i = 1'b0; issue_rd_i = '0;
    rs1_addr_i = '0; rs2_addr_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid_i = '0; rs1_addr_i = 5'd5; rs2_addr_i = 5'd5;
    #1;
    n_cmp++; if (w_en_o !== 1'b0) begin n_err++; $display("FAIL reset_w_en: got %0h want 0", w_en_o); end
    n_cmp++; if (w_addr_o !== 5'd0) begin n_err++; $display("FAIL reset_w_addr: got %0h want 0", w_addr_o); end
    n_cmp++; if (w_data_o !== 32'd0) begin n_err++; $display("FAIL reset_w_data: got %0h want 0", w_data_o); end
    n_cmp++; if (rs1_busy_o !== 1'b0) begin n_err++; $display("FAIL reset_rs1_busy: got %0h want 0", rs1_busy_o); end
    n_cmp++; if (rs2_busy_o !== 1'b0) begin n_err++; $display("FAIL reset_rs2_busy: got %0h want 0", rs2_busy_o); end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 5'd0, 32'd0);
    #1;
    n_cmp++; if (req_ready_o !== 3'b001) begin n_err++; $display("FAIL reset_ready_req0: got %0b want 001", req_ready_o); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  eg;
    logic [4:0]  ea;
    logic [31:0] ed;
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h0000_000A);
    set_req(1, 1'b1, 5'd2, 32'h0000_000B);
    set_req(2, 1'b1, 5'd3, 32'h0000_000C);
    #1;
    for (int i = 0; i < 4; i++) begin
      eg = 3'(1 << (i % 3));
      ea = 5'(1 + i % 3);
      ed = 32'(10 + i % 3);
      n_cmp++; if (req_ready_o !== eg) begin n_err++; $display("FAIL rr_grant[%0d]: got %0b want %0b", i, req_ready_o, eg); end
      @(posedge clk); #1;
      n_cmp++; if (w_en_o !== 1'b1) begin n_err++; $display("FAIL rr_w_en[%0d]: got %0h want 1", i, w_en_o); end
      n_cmp++; if (w_addr_o !== ea) begin n_err++; $display("FAIL rr_w_addr[%0d]: got %0h want %0h", i, w_addr_o, ea); end
      n_cmp++; if (w_data_o !== ed) begin n_err++; $display("FAIL rr_w_data[%0d]: got %0h want %0h", i, w_data_o, ed); end
    end
  endtask

  task automatic test_x0_write();
    do_reset();
    set_req(1, 1'b1, 5'd0, 32'h0000_DEAD);
    #1;
    n_cmp++; if (req_ready_o !== 3'b010) begin n_err++; $display("FAIL x0_grant: got %0b want 010", req_ready_o); end
    @(posedge clk); #1;
    n_cmp++; if (w_en_o !== 1'b0) begin n_err++; $display("FAIL x0_w_en: got %0h want 0", w_en_o); end
    n_cmp++; if (w_addr_o !== 5'd0) begin n_err++; $display("FAIL x0_w_addr: got %0h want 0", w_addr_o); end
    n_cmp++; if (w_data_o !== 32'd0) begin n_err++; $display("FAIL x0_w_data: got %0h want 0", w_data_o); end
    set_req(0, 1'b1, 5'd1, 32'h1);
    set_req(1, 1'b1, 5'd2, 32'h2);
    set_req(2, 1'b1, 5'd3, 32'h3);
    #1;
    n_cmp++; if (req_ready_o !== 3'b100) begin n_err++; $display("FAIL x0_ptr_adv: got %0b want 100", req_ready_o); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue_en_i = 1'b1; issue_rd_i = 5'd5; rs1_addr_i = 5'd5; rs2_addr_i = 5'd0;
    #1;
    n_cmp++; if (rs1_busy_o !== 1'b0) begin n_err++; $display("FAIL sb_issue_cycle: got %0h want 0", rs1_busy_o); end
    @(negedge clk);
    issue_en_i = 1'b0;
    #1;
    n_cmp++; if (rs1_busy_o !== 1'b1) begin n_err++; $display("FAIL sb_busy_next: got %0h want 1", rs1_busy_o); end
    @(negedge clk); #1;
    n_cmp++; if (rs1_busy_o !== 1'b1) begin n_err++; $display("FAIL sb_busy_hold: got %0h want 1", rs1_busy_o); end
    set_req(1, 1'b1, 5'd5, 32'h1234_5678);
    #1;
    n_cmp++; if (req_ready_o !== 3'b010) begin n_err++; $display("FAIL sb_lsu_grant: got %0b want 010", req_ready_o); end
    @(posedge clk); #1;
    n_cmp++; if (w_en_o !== 1'b1) begin n_err++; $display("FAIL sb_w_en: got %0h want 1", w_en_o); end
    n_cmp++; if (w_addr_o !== 5'd5) begin n_err++; $display("FAIL sb_w_addr: got %0h want 5", w_addr_o); end
    n_cmp++; if (rs1_busy_o !== 1'b0) begin n_err++; $display("FAIL sb_inflight_busy: got %0h want 0", rs1_busy_o); end
    n_cmp++; if (rs2_busy_o !== 1'b0) begin n_err++; $display("FAIL sb_x0_busy: got %0h want 0", rs2_busy_o); end
    @(negedge clk);
    set_req(1, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    n_cmp++; if (w_en_o !== 1'b0) begin n_err++; $display("FAIL sb_idle_w_en: got %0h want 0", w_en_o); end
    n_cmp++; if (rs1_busy_o !== 1'b0) begin n_err++; $display("FAIL sb_cleared: got %0h want 0", rs1_busy_o); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    issue_en_i = 1'b1; issue_rd_i = 5'd7; rs1_addr_i = 5'd7;
    @(negedge clk);
    issue_en_i = 1'b0;
    set_req(0, 1'b1, 5'd7, 32'h0000_0077);
    @(posedge clk); #1;
    n_cmp++; if (w_addr_o !== 5'd7) begin n_err++; $display("FAIL same_w_addr: got %0h want 7", w_addr_o); end
    n_cmp++; if (rs1_busy_o !== 1'b0) begin n_err++; $display("FAIL same_inflight: got %0h want 0", rs1_busy_o); end
    @(negedge clk);
    set_req(0, 1'b0, 5'd0, 32'd0);
    issue_en_i = 1'b1; issue_rd_i = 5'd7;
    @(posedge clk); #1;
    n_cmp++; if (w_en_o !== 1'b0) begin n_err++; $display("FAIL same_w_en: got %0h want 0", w_en_o); end
    n_cmp++; if (rs1_busy_o !== 1'b1) begin n_err++; $display("FAIL same_set_wins: got %0h want 1", rs1_busy_o); end
    @(negedge clk);
    issue_en_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rs1_busy_o !== 1'b1) begin n_err++; $display("FAIL same_set_hold: got %0h want 1", rs1_busy_o); end
  endtask

  task automatic test_flush();
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h1);
    set_req(1, 1'b1, 5'd2, 32'h2);
    set_req(2, 1'b1, 5'd3, 32'h3);
    flush_i = 1'b1;
    #1;
    n_cmp++; if (req_ready_o !== 3'b000) begin n_err++; $display("FAIL flush_grant: got %0b want 000", req_ready_o); end
    @(posedge clk); #1;
    n_cmp++; if (w_en_o !== 1'b0) begin n_err++; $display("FAIL flush_w_en: got %0h want 0", w_en_o); end
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    n_cmp++; if (req_ready_o !== 3'b001) begin n_err++; $display("FAIL flush_ptr_hold: got %0b want 001", req_ready_o); end
    @(posedge clk); #1;
    n_cmp++; if (w_addr_o !== 5'd1) begin n_err++; $display("FAIL flush_after_addr: got %0h want 1", w_addr_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    rs1_addr_i = 5'd9; issue_en_i = 1'b1; issue_rd_i = 5'd9;
    @(negedge clk);
    issue_rd_i = 5'd10;
    set_req(0, 1'b1, 5'd10, 32'hCAFE_F00D);
    @(posedge clk); #1;
    n_cmp++; if (w_en_o !== 1'b1) begin n_err++; $display("FAIL arst_pre_w_en: got %0h want 1", w_en_o); end
    n_cmp++; if (rs1_busy_o !== 1'b1) begin n_err++; $display("FAIL arst_pre_busy: got %0h want 1", rs1_busy_o); end
    @(negedge clk);
    issue_en_i = 1'b0;
    set_req(0, 1'b0, 5'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (w_en_o !== 1'b0) begin n_err++; $display("FAIL arst_w_en: got %0h want 0", w_en_o); end
    n_cmp++; if (w_addr_o !== 5'd0) begin n_err++; $display("FAIL arst_w_addr: got %0h want 0", w_addr_o); end
    n_cmp++; if (w_data_o !== 32'd0) begin n_err++; $display("FAIL arst_w_data: got %0h want 0", w_data_o); end
    n_cmp++; if (rs1_busy_o !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %0h want 0", rs1_busy_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_x0_write();
    test_scoreboard();
    test_same_cycle();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_scheduler.md
# wb_scheduler

Write-back scheduler for the integer register file. It shares the register file's single write port among `REQ_NUM` write-back requesters (ALU, LSU, MDU) using round-robin valid/ready arbitration. It drives the write port from a registered stage and keeps a per-register pending scoreboard so that issue logic can stall on read-after-write hazards. It sits between the execute/memory units and the register file.

## Interface
- `REQ_NUM`, default 3: number of write-back requesters, range 2..4; index 0 is the ALU.
- `clk` input, 1 bit: core clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid_i` input, `REQ_NUM` bits: per-requester write-back valid.
- `req_addr_i` input, `REQ_NUM`*5 bits: destination register; requester k uses bits [5k+4:5k].
- `req_data_i` input, `REQ_NUM`*32 bits: write data; requester k uses bits [32k+31:32k].
- `req_ready_o` output, `REQ_NUM` bits: one-hot grant; all zeros when there is no grant.
- `flush_i` input, 1 bit: synchronous; suppresses all grants in the current cycle.
- `issue_en_i` input, 1 bit: an instruction with a destination register issues this cycle.
- `issue_rd_i` input, `RegAddrBus`: destination of the issuing instruction.
- `rs1_addr_i`, `rs2_addr_i` input, `RegAddrBus`: source operands to check for hazards.
- `rs1_busy_o`, `rs2_busy_o` output, 1 bit: the source register has a pending write that is not yet visible.
- `w_en_o` output, 1 bit: register file write enable.
- `w_addr_o` output, `RegAddrBus`: register file write address.
- `w_data_o` output, `RegDataBus`: register file write data.

## Operation
- Handshake: a transfer for requester k occurs when `req_valid_i[k] & req_ready_o[k]`.
  - Once `req_valid_i[k]` is asserted, the requester holds it, together with stable addr/data, until the transfer. This is a requester obligation, checked by assertion.
- Arbitration: `req_ready_o` is combinational from `req_valid_i`, the RR pointer `ptr` and `flush_i`.
  - The grant goes to the first valid index at or after `ptr`, in modular order.
  - At most one grant per cycle.
  - `flush_i`=1 forces `req_ready_o`=0.
- Pointer: after a transfer from k, `ptr` ← (k+1) mod `REQ_NUM`. With no transfer, `ptr` holds.
- Output stage: registered.
  - On a transfer with addr≠0: `w_en_o`←1, `w_addr_o`←addr, `w_data_o`←data.
  - On a transfer to x0: the transfer is accepted and consumed, and `w_en_o`←0.
  - Whenever `w_en_o`←0 (no transfer, or a transfer to x0), `w_addr_o` and `w_data_o` are also cleared to 0. An idle port therefore always presents addr 0 / data 0, so register-file address-match forwarding yields 0.
- Scoreboard: `pend[31:1]`; `pend[0]` is constantly 0.
  - Set: `issue_en_i` with `issue_rd_i`≠0 sets `pend[issue_rd_i]`.
  - Clear: `w_en_o`=1 clears `pend[w_addr_o]`, since the register file commits that cycle.
  - If set and clear hit the same register in the same cycle, set wins (a new producer was issued).
  - Issuing to a register whose bit is already pending is illegal; upstream stalls on it. Checked by assertion.
- Busy: `rsN_busy_o` = `pend[rsN] & ~(w_en_o & w_addr_o==rsN)`.
  - The write in flight is forwarded by the register file in the same cycle, so the register is not busy in that cycle.
  - rs=0 is never busy.

## Timing
- Reset values:
  - `ptr`=0.
  - `pend`=0.
  - `w_en_o`=0, `w_addr_o`=0, `w_data_o`=0.
  - `req_ready_o` follows the combinational rule with `ptr`=0.
  - `rsN_busy_o`=0.
- Latency:
  - A transfer at edge N gives `w_en_o`=1 during cycle N+1.
  - The register file is updated at edge N+1.
  - The pend bit is clear after edge N+1 and reads as not busy during cycle N+1.
- Throughput: one write per cycle. Back-to-back grants to different requesters are allowed; there are no bubbles.
- Issue set at edge M: `busy`=1 from cycle M+1.
  - Issue and read of the same register in one cycle shows `busy`=0, because the bit is set only at the edge.
- Fairness: a requester held valid is granted within `REQ_NUM` cycles, provided `flush_i` is low.
- Reset mid-operation: in-flight output writes are dropped and `pend` clears immediately (asynchronously).

## Test plan
- Reset, then idle:
  - `w_en_o`/`w_addr_o`/`w_data_o`=0.
  - Busy outputs are 0.
  - Requester 0 alone valid gives `req_ready_o`=001.
- All three valid continuously, with addrs 1/2/3 and data A/B/C:
  - Grants 001, 010, 100, 001 on consecutive cycles.
  - `w_addr_o` 1, 2, 3, 1, each one cycle after its grant.
- Requester 1 writes x0 with data 0xDEAD:
  - `req_ready_o`=010 and the transfer completes.
  - Next cycle `w_en_o`=0, `w_addr_o`=0, `w_data_o`=0.
  - `ptr` advances to 2.
- Scoreboard:
  - Issue rd=5. Query rs1=5 → busy from the next cycle.
  - LSU write-back to x5 transfers → busy=0 in the `w_en_o` cycle. `pend[5]`=0 afterwards.
- Same-cycle set and clear:
  - `w_en_o` to x7 while issuing rd=7 → `pend[7]`=1 afterwards.
- `flush_i`=1 with all valid:
  - `req_ready_o`=000 and `ptr` unchanged.
- `rst_n` low with `w_en_o`=1 and pend bits set:
  - All outputs clear immediately, without waiting for a clock edge.
